// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the round-robin register write arbiter.
package reg_arb_pkg;

  typedef enum logic {ARB_IDLE = 1'b0, ARB_LOCKED = 1'b1} arb_state_e;

  // Modulo-n increment; the caller guarantees p < n, so one compare is enough.
  function automatic int unsigned ptr_inc(input int unsigned p, input int unsigned n);
    return (p + 1 >= n) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping modulo NREQ.
// Purely combinational; any_req is low when nothing is requesting.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int OW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [OW-1:0]   ptr,
  output logic [OW-1:0]   winner,
  output logic            any_req
);

  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    // Scan from the far end back toward ptr so the closest request wins last.
    for (int i = NREQ - 1; i >= 0; i--) begin
      int idx;
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) begin
        winner  = OW'(idx);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register among NREQ writers, with bounded
// burst locking. Grant is combinational; q/q_valid update at the edge ending the grant.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter  int NREQ     = 4,
  parameter  int WIDTH    = 8,
  parameter  int MAX_HOLD = 4,
  localparam int OW       = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       lock,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic                  q_valid,
  output logic [OW-1:0]         owner,
  output logic                  busy
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  arb_state_e       state_q, state_d;
  logic [OW-1:0]    ptr_q, ptr_d;
  logic [OW-1:0]    cur_q, cur_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [WIDTH-1:0] data_q;
  logic             vld_q;
  logic [OW-1:0]    owner_q;

  logic [OW-1:0]    winner;
  logic             any_req;
  logic             wr_en;
  logic [OW-1:0]    sel;

  rr_pick #(
    .NREQ (NREQ),
    .OW   (OW)
  ) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      cur_q   <= '0;
      hold_q  <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cur_q   <= cur_d;
      hold_q  <= hold_d;
      vld_q   <= wr_en;
      if (wr_en) begin
        data_q  <= wdata[int'(sel)*WIDTH +: WIDTH];
        owner_q <= sel;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cur_d   = cur_q;
    hold_d  = hold_q;
    wr_en   = 1'b0;
    sel     = winner;
    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          wr_en = 1'b1;
          // A one-write limit makes a lock meaningless, so treat it as unlocked.
          if (lock[winner] && (MAX_HOLD > 1)) begin
            state_d = ARB_LOCKED;
            cur_d   = winner;
            hold_d  = HW'(1);
          end else begin
            ptr_d = OW'(ptr_inc(32'(winner), NREQ));
          end
        end
      end
      ARB_LOCKED: begin
        sel = cur_q;
        if (req[cur_q]) begin
          wr_en  = 1'b1;
          hold_d = hold_q + HW'(1);
        end
        if (!req[cur_q] || !lock[cur_q] || (int'(hold_q) + 1 == MAX_HOLD)) begin
          state_d = ARB_IDLE;
          ptr_d   = OW'(ptr_inc(32'(cur_q), NREQ));
          hold_d  = '0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    gnt = '0;
    if (rst_ && wr_en) gnt[sel] = 1'b1;
  end

  assign q       = data_q;
  assign q_valid = vld_q;
  assign owner   = owner_q;
  assign busy    = (state_q == ARB_LOCKED);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed plus randomized checks of reg_write_arbiter against a rule-level model.
module tb_reg_write_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MH = 4;

  logic           clk = 1'b0;
  logic           rst_;
  logic [N-1:0]   req, lock, gnt;
  logic [N*W-1:0] wdata;
  logic [W-1:0]   q;
  logic           q_valid, busy;
  logic [1:0]     owner;

  int tests = 0;
  int fails = 0;

  // Reference state: plain integers, one bit of mode.
  bit m_locked;
  int m_ptr, m_cur, m_hold, m_q, m_vld, m_owner;

  always #5 clk = ~clk;

  reg_write_arbiter #(.NREQ(N), .WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_(rst_), .req(req), .lock(lock), .wdata(wdata),
    .gnt(gnt), .q(q), .q_valid(q_valid), .owner(owner), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Which requester the rules say is granted this cycle, or -1.
  function automatic int model_pick(input logic r, input logic [N-1:0] rq);
    if (!r) return -1;
    if (m_locked) return rq[m_cur] ? m_cur : -1;
    for (int k = 0; k < N; k++)
      if (rq[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  // One clock cycle: drive at negedge, check grant before the edge, state after it.
  task automatic cyc(input logic r, input logic [N-1:0] rq, input logic [N-1:0] lk,
                     input logic [N*W-1:0] wd);
    int w;
    logic [N-1:0] eg;
    @(negedge clk);
    rst_ = r; req = rq; lock = lk; wdata = wd;
    #1;
    w  = model_pick(r, rq);
    eg = (w < 0) ? '0 : N'(1 << w);
    check("gnt", 32'(gnt), 32'(eg));
    check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    @(posedge clk);
    if (!r) begin
      m_locked = 0; m_ptr = 0; m_cur = 0; m_hold = 0; m_q = 0; m_vld = 0; m_owner = 0;
    end else begin
      m_vld = (w >= 0);
      if (w >= 0) begin
        m_q = int'(wd[w*W +: W]);
        m_owner = w;
      end
      if (!m_locked) begin
        if (w >= 0) begin
          if (lk[w] && MH > 1) begin
            m_locked = 1; m_cur = w; m_hold = 1;
          end else m_ptr = (w + 1) % N;
        end
      end else begin
        if (w >= 0) m_hold = m_hold + 1;
        if (w < 0 || !lk[m_cur] || m_hold >= MH) begin
          m_locked = 0; m_ptr = (m_cur + 1) % N; m_hold = 0;
        end
      end
    end
    #1;
    check("q", 32'(q), 32'(m_q));
    check("q_valid", 32'(q_valid), 32'(m_vld));
    check("owner", 32'(owner), 32'(m_owner));
    check("busy", 32'(busy), 32'(m_locked));
  endtask

  logic [N*W-1:0] wd_a0;
  logic [N*W-1:0] rnd_wd;

  initial begin
    rst_ = 1'b0; req = '0; lock = '0; wdata = '0;
    m_locked = 0; m_ptr = 0; m_cur = 0; m_hold = 0; m_q = 0; m_vld = 0; m_owner = 0;
    wd_a0 = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    // Reset held with every requester active: no grant, cleared outputs.
    cyc(1'b0, 4'b1111, 4'b0000, wd_a0);
    cyc(1'b0, 4'b1111, 4'b0000, wd_a0);
    check("rst_q", 32'(q), 32'h0);
    check("rst_q_valid", 32'(q_valid), 32'h0);

    // Round-robin rotation 0,1,2,3,0 with back-to-back writes.
    for (int i = 0; i < 5; i++) cyc(1'b1, 4'b1111, 4'b0000, wd_a0);
    check("rr_last_q", 32'(q), 32'hA0);

    // Lock burst by requester 1 with requester 2 pending.
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'b0110, 4'b0010, wd_a0);
    check("burst_busy", 32'(busy), 32'h1);
    cyc(1'b1, 4'b0110, 4'b0000, wd_a0);
    cyc(1'b1, 4'b0110, 4'b0000, wd_a0);

    // Hold limit: requester 0 locks forever, requester 3 waits.
    for (int i = 0; i < 10; i++) cyc(1'b1, 4'b1001, 4'b0001, wd_a0);

    // Sparse single pulse, then idle.
    cyc(1'b1, 4'b0000, 4'b0000, wd_a0);
    cyc(1'b1, 4'b0100, 4'b0000, {8'h00, 8'h5C, 8'h00, 8'h00});
    check("sparse_q", 32'(q), 32'h5C);
    cyc(1'b1, 4'b0000, 4'b0000, wd_a0);
    cyc(1'b1, 4'b0000, 4'b0000, wd_a0);
    check("sparse_hold_q", 32'(q), 32'h5C);

    // Reset in the middle of a burst owned by requester 2.
    cyc(1'b0, 4'b0000, 4'b0000, wd_a0);
    cyc(1'b1, 4'b0100, 4'b0100, wd_a0);
    cyc(1'b1, 4'b0100, 4'b0100, wd_a0);
    cyc(1'b0, 4'b0100, 4'b0100, wd_a0);
    check("midlock_busy", 32'(busy), 32'h0);
    cyc(1'b1, 4'b1111, 4'b0000, wd_a0);
    check("midlock_owner", 32'(owner), 32'h0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      rnd_wd = {$urandom, $urandom} >> 0;
      cyc(($urandom_range(0, 40) != 0), N'($urandom), N'($urandom), rnd_wd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
